ps2_host_if: RTL and testbench
==============================

PS2_HOST_IF -- requirements
Module: ps2_host_if

Interface
REQ-001 Parameter FILTER_LEN, 8: cycles ps2_clk must be stable before the filtered clock changes.
REQ-002 Parameter FIFO_DEPTH, 8: scan-code FIFO entries; power of two, 2..64.
REQ-003 Parameter TIMEOUT_CYC, 100000: max clk cycles between falling edges inside a frame.
REQ-004 Parameter INHIBIT_CYC, 5000: host clock-inhibit duration before a transmit.
REQ-005 clk  in  1  single clock; all logic on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 ps2_clk, ps2_data  in  1 each  raw PS/2 line levels, asynchronous.
REQ-008 ps2_clk_oe, ps2_data_oe  out  1 each  1 = pull line low (open-drain enable).
REQ-009 rd_data  out  8  FIFO head byte; rd_valid  out  1  FIFO non-empty; rd_ready  in  1  pop request.
REQ-010 fifo_level  out  $clog2(FIFO_DEPTH)+1  current entry count.
REQ-011 err_parity, err_frame, err_timeout, err_overflow  out  1 each  one-cycle error pulses.
REQ-012 tx_data  in  8; tx_start  in  1; tx_busy  out  1; tx_done  out  1 (pulse); tx_nack  out  1 (pulse).

Function
REQ-013 ps2_data and ps2_clk SHALL pass a 2-flop synchroniser; filtered clock goes 1 only after FILTER_LEN consecutive 1 samples, 0 only after FILTER_LEN consecutive 0 samples.
REQ-014 A one-cycle fall event SHALL be generated on each filtered-clock 1->0 transition; data is sampled in that cycle.
REQ-015 RX FSM states IDLE, DATA, PARITY, STOP: IDLE->DATA on fall with data=0 (data=1 ignored); DATA takes 8 bits LSB first; PARITY samples one bit; STOP samples one bit then ->IDLE.
REQ-016 In STOP: stop=1 and odd parity over 9 bits correct -> push byte; parity wrong -> err_parity; stop=0 -> err_frame (frame takes priority if both).
REQ-017 In any state except IDLE, TIMEOUT_CYC cycles without a fall event SHALL abort to IDLE, discard the partial byte, pulse err_timeout.
REQ-018 rd_valid SHALL rise exactly 2 cycles after the stop-bit fall event when the FIFO was empty.
REQ-019 Pop occurs when rd_valid and rd_ready are both high; rd_data shows the next entry the following cycle.
REQ-020 Push to a full FIFO without same-cycle pop SHALL drop the new byte and pulse err_overflow; push+pop same cycle when full SHALL be accepted, level unchanged.
REQ-021 Read/write pointers SHALL wrap modulo FIFO_DEPTH; rd_ready when empty has no effect.
REQ-022 TX FSM: tx_start in IDLE latches tx_data, sets tx_busy, drives clock low INHIBIT_CYC cycles, drives data low, releases clock, then on each device fall event presents next bit (8 data LSB first, odd parity, released stop), then samples ack.
REQ-023 Ack data=0 -> tx_done pulse; ack data=1 -> tx_nack pulse; TIMEOUT_CYC without fall event after clock release -> err_timeout, lines released, TX to IDLE.
REQ-024 tx_start while tx_busy SHALL be ignored; RX FSM held in IDLE while tx_busy.

Reset
REQ-025 Reset SHALL clear FIFO (level 0, rd_valid 0), both FSMs to IDLE, all pulses 0, tx_busy 0, both oe outputs 0, filter state to all-1 (line idle).
REQ-026 Reset mid-frame or mid-transmit SHALL discard the transfer and release both lines the cycle after reset is sampled.

Configuration
REQ-027 Macro PS2_HOST_TX_EN: defined -> REQ-022..024 implemented; undefined -> TX ports still present, tx_start ignored, tx_busy/tx_done/tx_nack and both oe outputs tied 0.

Structure
REQ-028 Package ps2_pkg SHALL hold RX/TX state enums, frame constants (8 data bits, odd parity) and host command constants (0xED set LEDs, 0xFF reset).
REQ-029 FIFO SHALL be a separate sub-module ps2_code_fifo (parametrised depth/width, show-ahead).

Verification
REQ-030 Frame 0x1C with correct parity -> rd_valid 2 cycles after stop fall, rd_data=0x1C, level=1.
REQ-031 Frame 0x5A with parity bit inverted -> err_parity one pulse, level unchanged.
REQ-032 Stop start bit then clock held high TIMEOUT_CYC cycles after 3rd data bit -> err_timeout, next valid frame 0xF0 received intact.
REQ-033 FIFO_DEPTH+1 frames 0x01.. with rd_ready=0 -> level=FIFO_DEPTH, err_overflow once, pops return 0x01..FIFO_DEPTH in order.
REQ-034 With PS2_HOST_TX_EN, tx_start tx_data=0xED, device model acks -> clock low INHIBIT_CYC cycles, serial bits 1,0,1,1,0,1,1,1 parity 1, tx_done pulse.
REQ-035 Glitch on ps2_clk shorter than FILTER_LEN cycles -> no fall event, no bit consumed.

Source files
------------

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - PS/2 frame constants, host commands and FSM state types.
package ps2_pkg;
    localparam int         DATA_BITS    = 8;
    localparam logic       ODD_PARITY   = 1'b1;
    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_RESET    = 8'hFF;

    typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_INHIBIT, TX_BITS, TX_ACK} tx_state_t;

    // Parity bit that makes the 9-bit (data + parity) word have an odd number of ones.
    function automatic logic odd_parity(input logic [DATA_BITS-1:0] b);
        return ODD_PARITY ^ (^b);
    endfunction
endpackage

// File: rtl/ps2_code_fifo.sv
// rtl/ps2_code_fifo.sv - Show-ahead scan-code FIFO; a push into a full FIFO is dropped unless a pop frees a slot.
module ps2_code_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level,
    output logic                   dropped
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (level == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && ((level != FULL_LVL) || do_pop);
    assign dropped = push && !do_push;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      level <= level + 1'b1;
            else if (!do_push && do_pop) level <= level - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/ps2_host_if.sv
// rtl/ps2_host_if.sv - PS/2 host: filtered line sampling, RX decoder with scan-code FIFO, optional transmitter.
// Define PS2_HOST_TX_EN to build the host-to-device transmitter; otherwise TX outputs are tied low.
module ps2_host_if
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int FIFO_DEPTH  = 8,
    parameter int TIMEOUT_CYC = 100000,
    parameter int INHIBIT_CYC = 5000
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        ps2_clk,
    input  logic                        ps2_data,
    output logic                        ps2_clk_oe,
    output logic                        ps2_data_oe,
    output logic [7:0]                  rd_data,
    output logic                        rd_valid,
    input  logic                        rd_ready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        err_parity,
    output logic                        err_frame,
    output logic                        err_timeout,
    output logic                        err_overflow,
    input  logic [7:0]                  tx_data,
    input  logic                        tx_start,
    output logic                        tx_busy,
    output logic                        tx_done,
    output logic                        tx_nack
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC - 1);
    localparam logic [2:0]    BIT_LAST  = 3'(DATA_BITS - 1);

    logic [1:0]    clk_sync;
    logic [1:0]    data_sync;
    logic          clk_filt;
    logic [FW-1:0] filt_cnt;
    logic          fall_evt;
    logic          rx_bit;

    logic [TW-1:0] to_cnt;
    logic          to_active;
    logic          timeout;
    logic          tx_wait;

    rx_state_t     rx_state;
    logic [2:0]    bit_cnt;
    logic [7:0]    rx_shift;
    logic          rx_par;
    logic          push;
    logic          fifo_empty;
    logic          fifo_dropped;

    assign rx_bit = data_sync[1];

    // The filtered clock only flips after FILTER_LEN agreeing samples; fall_evt marks the 1->0 flip.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            clk_filt  <= 1'b1;
            filt_cnt  <= '0;
            fall_evt  <= 1'b0;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
            fall_evt  <= 1'b0;
            if (clk_sync[1] == clk_filt) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FILT_LAST) begin
                filt_cnt <= '0;
                clk_filt <= clk_sync[1];
                fall_evt <= clk_filt;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    // One watchdog serves both directions; RX and TX are never active together.
    assign to_active = (rx_state != RX_IDLE) || tx_wait;
    assign timeout   = to_active && !fall_evt && (to_cnt == TO_LAST);

    always_ff @(posedge clk) begin
        if (reset || !to_active || fall_evt) to_cnt <= '0;
        else                                 to_cnt <= to_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state     <= RX_IDLE;
            bit_cnt      <= '0;
            rx_shift     <= '0;
            rx_par       <= 1'b0;
            push         <= 1'b0;
            err_parity   <= 1'b0;
            err_frame    <= 1'b0;
            err_timeout  <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            push         <= 1'b0;
            err_parity   <= 1'b0;
            err_frame    <= 1'b0;
            err_timeout  <= timeout;
            err_overflow <= fifo_dropped;
            if (tx_busy || timeout) begin
                rx_state <= RX_IDLE;
            end else if (fall_evt) begin
                case (rx_state)
                    RX_IDLE: begin
                        if (!rx_bit) begin
                            rx_state <= RX_DATA;
                            bit_cnt  <= '0;
                        end
                    end
                    RX_DATA: begin
                        rx_shift <= {rx_bit, rx_shift[7:1]};
                        bit_cnt  <= bit_cnt + 1'b1;
                        if (bit_cnt == BIT_LAST) rx_state <= RX_PARITY;
                    end
                    RX_PARITY: begin
                        rx_par   <= rx_bit;
                        rx_state <= RX_STOP;
                    end
                    RX_STOP: begin
                        rx_state <= RX_IDLE;
                        if (!rx_bit)                             err_frame  <= 1'b1;
                        else if (rx_par != odd_parity(rx_shift)) err_parity <= 1'b1;
                        else                                     push       <= 1'b1;
                    end
                    default: rx_state <= RX_IDLE;
                endcase
            end
        end
    end

    ps2_code_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (rx_shift),
        .pop       (rd_ready),
        .head      (rd_data),
        .empty     (fifo_empty),
        .level     (fifo_level),
        .dropped   (fifo_dropped)
    );

    assign rd_valid = !fifo_empty;

`ifdef PS2_HOST_TX_EN
    localparam int IW = $clog2(INHIBIT_CYC + 1);
    localparam logic [IW-1:0] INH_REQ  = IW'(INHIBIT_CYC - 2);
    localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYC - 1);

    tx_state_t     tx_state;
    logic [8:0]    tx_shift;
    logic [3:0]    tx_bit;
    logic [IW-1:0] tx_cnt;

    assign tx_wait = (tx_state == TX_BITS) || (tx_state == TX_ACK);

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state    <= TX_IDLE;
            tx_shift    <= '0;
            tx_bit      <= '0;
            tx_cnt      <= '0;
            tx_busy     <= 1'b0;
            tx_done     <= 1'b0;
            tx_nack     <= 1'b0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            tx_nack <= 1'b0;
            if (tx_wait && timeout) begin
                tx_state    <= TX_IDLE;
                tx_busy     <= 1'b0;
                ps2_clk_oe  <= 1'b0;
                ps2_data_oe <= 1'b0;
            end else begin
                case (tx_state)
                    TX_IDLE: begin
                        if (tx_start) begin
                            tx_shift   <= {odd_parity(tx_data), tx_data};
                            tx_bit     <= '0;
                            tx_cnt     <= '0;
                            tx_busy    <= 1'b1;
                            ps2_clk_oe <= 1'b1;
                            tx_state   <= TX_INHIBIT;
                        end
                    end
                    // Data goes low one cycle before the clock is released (request-to-send).
                    TX_INHIBIT: begin
                        tx_cnt <= tx_cnt + 1'b1;
                        if (tx_cnt == INH_REQ) ps2_data_oe <= 1'b1;
                        if (tx_cnt == INH_LAST) begin
                            ps2_clk_oe <= 1'b0;
                            tx_state   <= TX_BITS;
                        end
                    end
                    TX_BITS: begin
                        if (fall_evt) begin
                            if (tx_bit == 4'd9) begin
                                ps2_data_oe <= 1'b0;
                                tx_state    <= TX_ACK;
                            end else begin
                                ps2_data_oe <= ~tx_shift[0];
                                tx_shift    <= {1'b0, tx_shift[8:1]};
                                tx_bit      <= tx_bit + 1'b1;
                            end
                        end
                    end
                    TX_ACK: begin
                        if (fall_evt) begin
                            tx_done  <= !rx_bit;
                            tx_nack  <= rx_bit;
                            tx_busy  <= 1'b0;
                            tx_state <= TX_IDLE;
                        end
                    end
                    default: tx_state <= TX_IDLE;
                endcase
            end
        end
    end
`else
    logic unused_tx;
    assign unused_tx   = ^{tx_data, tx_start};
    assign tx_wait     = 1'b0;
    assign tx_busy     = 1'b0;
    assign tx_done     = 1'b0;
    assign tx_nack     = 1'b0;
    assign ps2_clk_oe  = 1'b0;
    assign ps2_data_oe = 1'b0;
`endif
endmodule

// File: tb/tb_ps2_host_if.sv
// tb/tb_ps2_host_if.sv - Self-checking bench for ps2_host_if with a device model and a queue-based reference.
module tb_ps2_host_if;
    localparam int FL    = 4;
    localparam int DEPTH = 4;
    localparam int TO    = 300;
    localparam int INH   = 50;
    localparam int HALF  = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    wire        ps2_clk;
    wire        ps2_data;
    logic       ps2_clk_oe, ps2_data_oe;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_ready = 1'b0;
    logic [2:0] fifo_level;
    logic       err_parity, err_frame, err_timeout, err_overflow;
    logic [7:0] tx_data = 8'h00;
    logic       tx_start = 1'b0;
    logic       tx_busy, tx_done, tx_nack;

    // Open-drain lines: either side may pull low.
    assign ps2_clk  = dev_clk & ~ps2_clk_oe;
    assign ps2_data = dev_data & ~ps2_data_oe;

    ps2_host_if #(
        .FILTER_LEN (FL),
        .FIFO_DEPTH (DEPTH),
        .TIMEOUT_CYC(TO),
        .INHIBIT_CYC(INH)
    ) dut (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .fifo_level(fifo_level),
        .err_parity(err_parity), .err_frame(err_frame), .err_timeout(err_timeout),
        .err_overflow(err_overflow), .tx_data(tx_data), .tx_start(tx_start),
        .tx_busy(tx_busy), .tx_done(tx_done), .tx_nack(tx_nack)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_par = 0, n_frm = 0, n_to = 0, n_ovf = 0, n_done = 0, n_nack = 0;
    int e_par = 0, e_frm = 0, e_to = 0, e_ovf = 0;
    logic [7:0] exp_q[$];

    always @(negedge clk) begin
        if (err_parity === 1'b1)   n_par++;
        if (err_frame === 1'b1)    n_frm++;
        if (err_timeout === 1'b1)  n_to++;
        if (err_overflow === 1'b1) n_ovf++;
        if (tx_done === 1'b1)      n_done++;
        if (tx_nack === 1'b1)      n_nack++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ps2_bit(input logic b);
        dev_data = b;
        wait_cyc(HALF);
        dev_clk = 1'b0;
        wait_cyc(HALF);
        dev_clk = 1'b1;
    endtask

    // Device-to-host frame; lat = negedges from the stop-bit clock fall until rd_valid is seen high.
    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop,
                              input logic glitch, output int lat);
        logic [10:0] fr;
        logic par;
        par = ($countones(b) % 2 == 0);
        fr  = {~bad_stop, par ^ bad_par, b, 1'b0};
        lat = 0;
        for (int i = 0; i < 10; i++) begin
            if (glitch && i == 4) begin
                dev_data = fr[i];
                wait_cyc(5);
                dev_clk = 1'b0;
                wait_cyc(FL - 1);
                dev_clk = 1'b1;
            end
            ps2_bit(fr[i]);
        end
        dev_data = fr[10];
        wait_cyc(HALF);
        dev_clk = 1'b0;
        for (int j = 1; j <= HALF; j++) begin
            @(negedge clk);
            if (rd_valid === 1'b1 && lat == 0) lat = j;
        end
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        wait_cyc(HALF);
    endtask

    task automatic model_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
        if (bad_stop)                    e_frm++;
        else if (bad_par)                e_par++;
        else if (exp_q.size() == DEPTH)  e_ovf++;
        else                             exp_q.push_back(b);
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_level"}, fifo_level, exp_q.size());
        chk({tag, "_valid"}, rd_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) chk({tag, "_head"}, rd_data, exp_q[0]);
        chk({tag, "_err_par"}, n_par, e_par);
        chk({tag, "_err_frm"}, n_frm, e_frm);
        chk({tag, "_err_to"}, n_to, e_to);
        chk({tag, "_err_ovf"}, n_ovf, e_ovf);
    endtask

    task automatic pop_one(input string tag);
        chk({tag, "_pop_head"}, rd_data, exp_q[0]);
        rd_ready = 1'b1;
        @(negedge clk);
        rd_ready = 1'b0;
        void'(exp_q.pop_front());
        check_state(tag);
    endtask

    initial begin
        int lat;
        logic [7:0] b;
        int kind;
        int cnt;
        logic [9:0] cap;

        wait_cyc(5);
        reset = 1'b0;
        wait_cyc(2);
        chk("reset_level", fifo_level, 0);
        chk("reset_valid", rd_valid, 0);
        chk("reset_clk_oe", ps2_clk_oe, 0);
        chk("reset_data_oe", ps2_data_oe, 0);
        chk("reset_busy", tx_busy, 0);
        chk("reset_pulses", n_par + n_frm + n_to + n_ovf + n_done + n_nack, 0);

        // Clean frame into an empty FIFO: rd_valid two cycles after the filtered stop fall.
        send_frame(8'h1C, 1'b0, 1'b0, 1'b0, lat);
        model_frame(8'h1C, 1'b0, 1'b0);
        chk("lat_1c", lat, FL + 4);
        check_state("f1c");
        pop_one("f1c");

        send_frame(8'h5A, 1'b1, 1'b0, 1'b0, lat);
        model_frame(8'h5A, 1'b1, 1'b0);
        check_state("f5a_par");

        b = 8'($urandom);
        send_frame(b, 1'b1, 1'b1, 1'b0, lat);
        model_frame(b, 1'b1, 1'b1);
        check_state("stop_err");

        b = 8'($urandom);
        send_frame(b, 1'b0, 1'b0, 1'b1, lat);
        model_frame(b, 1'b0, 1'b0);
        check_state("glitch");
        pop_one("glitch");

        // Abandoned frame: start bit plus three data bits, then silence beyond the timeout.
        ps2_bit(1'b0);
        for (int i = 0; i < 3; i++) ps2_bit(1'b1);
        dev_data = 1'b1;
        wait_cyc(TO + 50);
        e_to++;
        check_state("timeout");
        send_frame(8'hF0, 1'b0, 1'b0, 1'b0, lat);
        model_frame(8'hF0, 1'b0, 1'b0);
        check_state("after_to");
        pop_one("after_to");

        for (int n = 0; n < 8; n++) begin
            b    = 8'($urandom);
            kind = $urandom_range(0, 4);
            send_frame(b, kind == 0, kind == 1, 1'b0, lat);
            model_frame(b, kind == 0, kind == 1);
            check_state("rand");
            if (exp_q.size() != 0 && $urandom_range(0, 1) == 1) pop_one("rand");
        end
        while (exp_q.size() != 0) pop_one("drain");

        rd_ready = 1'b1;
        wait_cyc(3);
        rd_ready = 1'b0;
        check_state("pop_empty");

        for (int n = 1; n <= DEPTH + 1; n++) begin
            send_frame(8'(n), 1'b0, 1'b0, 1'b0, lat);
            model_frame(8'(n), 1'b0, 1'b0);
        end
        check_state("overflow");
        chk("ovf_level", fifo_level, DEPTH);
        for (int n = 1; n <= DEPTH; n++) begin
            chk("ovf_order", rd_data, n);
            pop_one("ovf_pop");
        end

        // Reset in the middle of a frame discards it and leaves the lines released.
        send_frame(8'h33, 1'b0, 1'b0, 1'b0, lat);
        model_frame(8'h33, 1'b0, 1'b0);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        reset = 1'b1;
        wait_cyc(2);
        reset = 1'b0;
        exp_q.delete();
        wait_cyc(1);
        chk("midreset_clk_oe", ps2_clk_oe, 0);
        chk("midreset_data_oe", ps2_data_oe, 0);
        check_state("midreset");
        b = 8'($urandom);
        send_frame(b, 1'b0, 1'b0, 1'b0, lat);
        model_frame(b, 1'b0, 1'b0);
        check_state("post_reset");
        pop_one("post_reset");

`ifdef PS2_HOST_TX_EN
        tx_data  = 8'hED;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        cnt = 0;
        while (ps2_clk_oe === 1'b1 && cnt < 2 * INH) begin
            cnt++;
            if (cnt == 5) begin
                tx_data  = 8'hFF;
                tx_start = 1'b1;
            end else begin
                tx_start = 1'b0;
            end
            @(negedge clk);
        end
        chk("tx_inhibit_len", cnt, INH);
        chk("tx_rts_data_low", ps2_data, 0);
        chk("tx_busy", tx_busy, 1);
        wait_cyc(HALF);
        for (int i = 0; i < 11; i++) begin
            if (i == 10) dev_data = 1'b0;
            dev_clk = 1'b0;
            wait_cyc(HALF);
            if (i < 10) cap[i] = ps2_data;
            dev_clk = 1'b1;
            wait_cyc(HALF);
        end
        dev_data = 1'b1;
        wait_cyc(5);
        chk("tx_bits", cap[7:0], 8'hED);
        chk("tx_parity", cap[8], 1);
        chk("tx_stop", cap[9], 1);
        chk("tx_done", n_done, 1);
        chk("tx_nack", n_nack, 0);
        chk("tx_busy_end", tx_busy, 0);
        chk("tx_oe_end", {ps2_clk_oe, ps2_data_oe}, 0);
`else
        tx_data  = 8'hED;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (tx_busy !== 1'b0 || ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) cnt++;
            @(negedge clk);
        end
        cap = '0;
        chk("tx_disabled_quiet", cnt, 0);
        chk("tx_disabled_done", n_done + n_nack, cap);
`endif
        check_state("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
